lcd_text_buffer: RTL and testbench
==================================

Name: lcd_text_buffer

Overview:
- Double-buffered 32-character text store that sits directly upstream of the SC1602 4-bit LCD driver and supplies its `character` byte.
- A host, such as a UART decoder or counter formatter, writes ASCII into the back buffer.
- The LCD driver reads the front buffer by character index.
- A host swap request takes effect only at a frame boundary, marked by a toggle of the driver's `frame_rate`, so a displayed frame is never torn.

Parameters:
- NCHAR, 32: number of character cells; index 0-15 is row 0, 16-31 is row 1.
- AW, 5: index width; must equal clog2(NCHAR).
- FILL_CHAR, 8'h20: byte written by clear operations (ASCII space).

Ports:
- clk  in  1  system clock, same domain as the LCD driver.
- resetn  in  1  asynchronous active-low reset.
- wr_valid  in  1  host write request.
- wr_ready  out  1  high when a write is accepted this cycle.
- wr_addr  in  AW  back-buffer cell index.
- wr_data  in  8  ASCII byte to write.
- clear_req  in  1  one-cycle pulse: fill the back buffer with FILL_CHAR.
- swap_req  in  1  one-cycle pulse: request back/front exchange at the next frame boundary.
- swap_pending  out  1  a swap is requested and not yet performed.
- swap_done  out  1  one-cycle pulse in the cycle the exchange occurs.
- frame_rate  in  1  frame toggle from the LCD driver.
- rd_addr  in  AW  front-buffer index driven by the LCD-side sequencer.
- character  out  8  front-buffer byte at rd_addr.

Behaviour:
- Storage: two NCHAR x 8 register arrays, buf0 and buf1. Bit `sel` chooses the front buffer; the back buffer is the other one.
- Reset values:
  - sel=0, swap_pending=0, swap_done=0, wr_ready=0, character=FILL_CHAR.
  - frame_q=0.
  - FSM=INIT, clr_idx=0.
- FSM states:
  - INIT: every cycle writes FILL_CHAR to buf0[clr_idx] and buf1[clr_idx], then increments clr_idx. At clr_idx==NCHAR-1 the FSM goes to IDLE. Duration is exactly NCHAR cycles; wr_ready=0 throughout.
  - IDLE: wr_ready=1. On wr_valid, back[wr_addr] <= wr_data. On clear_req, clr_idx<=0 and the FSM goes to CLEAR. If clear_req and wr_valid arrive together, the clear takes priority and the write is not accepted (wr_ready is already 0 combinationally whenever clear_req=1).
  - CLEAR: writes FILL_CHAR to back[clr_idx] over NCHAR cycles, then returns to IDLE. wr_ready=0. A clear_req received during CLEAR is ignored.
- Frame edge:
  - frame_q <= frame_rate every cycle.
  - edge = frame_rate ^ frame_q (either polarity).
  - The LCD driver must reset frame_rate to a known value.
- Swap:
  - swap_req sets swap_pending. A swap_req while swap_pending=1 has no extra effect.
  - In a cycle with swap_pending=1, edge=1 and FSM==IDLE: sel<=~sel, swap_pending<=0, swap_done<=1 for exactly that cycle.
  - An edge that arrives during INIT or CLEAR is not remembered. The swap waits for the next edge after the return to IDLE.
  - A write accepted in the swap cycle targets the pre-swap back buffer, using the old sel.
  - A swap_req arriving in the same cycle as the swap is treated as a new request and re-sets pending.
- Read path:
  - character <= front[rd_addr], registered; latency is 1 clock.
  - The driver holds its index for at least 2 clocks (enable plus wait states), so the read is always valid before use.
  - The read uses sel after any update, i.e. the new front from the cycle after the swap.
- Reset mid-operation: all state returns to reset values and INIT re-runs in full. Partial buffer contents are not preserved.
- Index arithmetic: clr_idx is AW bits wide. Its terminal compare is against NCHAR-1, with no wrap.

Decomposition:
- Package lcd_pkg: NCHAR, AW, FILL_CHAR, row base constants ROW0_BASE=0 and ROW1_BASE=16, and the FSM state encoding {INIT, IDLE, CLEAR}.
- One sub-module, lcd_text_ram: a single NCHAR x 8 array with one write port and one registered read port, instantiated twice.
- The FSM, swap logic and frame-edge detect stay in the top level.

Test Plan:
- Reset release:
  - wr_ready=0 for 32 cycles, then 1.
  - rd_addr sweep 0..31 returns 0x20 everywhere.
- Write then swap:
  - Write 'H'(0x48) @0 and 'i'(0x69) @1, pulse swap_req, toggle frame_rate.
  - swap_done pulses 1 cycle after the toggle is sampled; rd_addr=0/1 then give 0x48/0x69.
  - Before the toggle, character stays 0x20.
- Deferred swap:
  - swap_req with no frame_rate toggle for 1000 cycles: swap_pending=1 and sel unchanged.
  - First toggle: swap occurs; swap_pending=0.
- Clear back buffer:
  - Fill back with 0x41, pulse clear_req.
  - 32 cycles with wr_ready=0; then swap shows 0x20 at all 32 cells.
  - A wr_valid during the clear is not accepted.
- Swap during clear:
  - swap_req plus a frame toggle mid-CLEAR: no swap.
  - Next toggle after IDLE: swap_done pulses once.
- Reset mid-clear:
  - Assert resetn=0 at clear cycle 10.
  - Outputs return to reset values; INIT runs 32 cycles; all cells read 0x20.

Source files
------------

// File: rtl/lcd_text_buffer_pkg.sv
// rtl/lcd_text_buffer_pkg.sv - shared constants and FSM encoding for the LCD text buffer
package lcd_pkg;

  localparam int NCHAR = 32;
  localparam int AW = 5;
  localparam logic [7:0] FILL_CHAR = 8'h20;

  localparam int ROW0_BASE = 0;
  localparam int ROW1_BASE = 16;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // First cell index of a display row (0 = top, 1 = bottom).
  function automatic logic [AW-1:0] row_base(input logic row);
    return row ? AW'(ROW1_BASE) : AW'(ROW0_BASE);
  endfunction

endpackage

// File: rtl/lcd_text_buffer_ram.sv
// rtl/lcd_text_buffer_ram.sv - NCHAR x 8 character store, one write port, registered read port
module lcd_text_ram
  import lcd_pkg::*;
#(
  parameter int         NCHAR    = lcd_pkg::NCHAR,
  parameter int         AW       = lcd_pkg::AW,
  parameter logic [7:0] RST_CHAR = lcd_pkg::FILL_CHAR
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [NCHAR];
  logic [7:0] rdata_q;

  // Cell contents are not reset; the owner sweeps them with a fill pattern.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= RST_CHAR;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_text_buffer.sv
// rtl/lcd_text_buffer.sv - double-buffered 32-cell text store feeding the SC1602 LCD driver
// Host writes the back buffer; front/back exchange only on a frame_rate toggle.
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int         NCHAR     = lcd_pkg::NCHAR,
  parameter int         AW        = lcd_pkg::AW,
  parameter logic [7:0] FILL_CHAR = lcd_pkg::FILL_CHAR
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clear_req,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          swap_done,
  input  logic          frame_rate,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    character
);

  state_e        state_q;
  logic [AW-1:0] clr_idx_q;
  logic          clr_last;

  logic sel_q, sel_d;
  logic swap_pending_q, swap_pending_d;
  logic swap_done_q, swap_done_d;
  logic frame_q;

  logic          frame_edge;
  logic          swap_fire;
  logic          host_wr;
  logic          fill_wr;
  logic          back_wr;
  logic          we0, we1;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [7:0]    rdata0, rdata1;

  assign clr_last = (clr_idx_q == AW'(NCHAR - 1));

  // Clear wins over a simultaneous write, so ready drops combinationally on clear_req.
  assign wr_ready = (state_q == IDLE) && !clear_req;
  assign host_wr  = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
    end else begin
      case (state_q)
        INIT, CLEAR: begin
          if (clr_last) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + AW'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
          end
        end
        default: begin
          state_q   <= INIT;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  // Edges seen outside IDLE are dropped, not queued: the swap waits for a later toggle.
  assign frame_edge = frame_rate ^ frame_q;
  assign swap_fire  = swap_pending_q && frame_edge && (state_q == IDLE);

  always_comb begin
    sel_d          = sel_q ^ swap_fire;
    swap_pending_d = swap_req || (swap_pending_q && !swap_fire);
    swap_done_d    = swap_fire;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q          <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      frame_q        <= 1'b0;
    end else begin
      sel_q          <= sel_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      frame_q        <= frame_rate;
    end
  end

  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;

  // INIT fills both arrays; CLEAR and host writes go to the back (non-selected) array
  // using the pre-swap sel, so a write in the swap cycle lands in the outgoing back.
  assign fill_wr = (state_q == INIT) || (state_q == CLEAR);
  assign back_wr = (state_q == CLEAR) || host_wr;
  assign we0     = (state_q == INIT) || (back_wr && sel_q);
  assign we1     = (state_q == INIT) || (back_wr && !sel_q);
  assign waddr   = fill_wr ? clr_idx_q : wr_addr;
  assign wdata   = fill_wr ? FILL_CHAR : wr_data;

  lcd_text_ram #(
    .NCHAR    (NCHAR),
    .AW       (AW),
    .RST_CHAR (FILL_CHAR)
  ) u_buf0 (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (we0),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  lcd_text_ram #(
    .NCHAR    (NCHAR),
    .AW       (AW),
    .RST_CHAR (FILL_CHAR)
  ) u_buf1 (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (we1),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  // Both arrays register the read; selecting with the current sel gives the new
  // front from the cycle after a swap.
  assign character = sel_q ? rdata1 : rdata0;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb/tb_lcd_text_buffer.sv - directed self-checking bench for lcd_text_buffer
module tb_lcd_text_buffer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       clear_req = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_pending;
  logic       swap_done;
  logic       frame_rate = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] character;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lcd_text_buffer dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clear_req    (clear_req),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .frame_rate   (frame_rate),
    .rd_addr      (rd_addr),
    .character    (character)
  );

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    rd_addr = a;
    @(negedge clk);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic toggle_frame();
    frame_rate = ~frame_rate;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
    n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL rst_swap_pending got=%b exp=0", swap_pending); end
    n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL rst_swap_done got=%b exp=0", swap_done); end
    n_tests++; if (character !== 8'h20) begin n_fail++; $display("FAIL rst_character got=%h exp=20", character); end
    resetn = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      n_tests++;
      if (wr_ready !== (i == 32)) begin
        n_fail++; $display("FAIL init_wr_ready cycle=%0d got=%b exp=%b", i, wr_ready, (i == 32));
      end
    end
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      n_tests++;
      if (character !== 8'h20) begin n_fail++; $display("FAIL init_sweep addr=%0d got=%h exp=20", a, character); end
    end
  endtask

  task automatic test_write_swap();
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ws_wr_ready got=%b exp=1", wr_ready); end
    do_write(5'd0, 8'h48);
    do_write(5'd1, 8'h69);
    pulse_swap();
    n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL ws_pending got=%b exp=1", swap_pending); end
    do_read(5'd0);
    n_tests++; if (character !== 8'h20) begin n_fail++; $display("FAIL ws_pre_toggle got=%h exp=20", character); end
    n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL ws_early_done got=%b exp=0", swap_done); end
    toggle_frame();
    n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL ws_done got=%b exp=1", swap_done); end
    n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL ws_pending_clr got=%b exp=0", swap_pending); end
    @(negedge clk);
    n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL ws_done_width got=%b exp=0", swap_done); end
    do_read(5'd0);
    n_tests++; if (character !== 8'h48) begin n_fail++; $display("FAIL ws_read0 got=%h exp=48", character); end
    do_read(5'd1);
    n_tests++; if (character !== 8'h69) begin n_fail++; $display("FAIL ws_read1 got=%h exp=69", character); end
    do_read(5'd2);
    n_tests++; if (character !== 8'h20) begin n_fail++; $display("FAIL ws_read2 got=%h exp=20", character); end
  endtask

  task automatic test_deferred_swap();
    int bad;
    bad = 0;
    do_write(5'd5, 8'h55);
    pulse_swap();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (swap_pending !== 1'b1 || swap_done !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL def_hold bad_cycles=%0d exp=0", bad); end
    do_read(5'd0);
    n_tests++; if (character !== 8'h48) begin n_fail++; $display("FAIL def_front_kept got=%h exp=48", character); end
    toggle_frame();
    n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL def_done got=%b exp=1", swap_done); end
    n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL def_pending got=%b exp=0", swap_pending); end
    do_read(5'd5);
    n_tests++; if (character !== 8'h55) begin n_fail++; $display("FAIL def_read5 got=%h exp=55", character); end
    do_read(5'd0);
    n_tests++; if (character !== 8'h20) begin n_fail++; $display("FAIL def_read0 got=%h exp=20", character); end
  endtask

  task automatic test_clear();
    for (int a = 0; a < 32; a++) do_write(5'(a), 8'h41);
    clear_req = 1'b1;
    wr_valid  = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 8'h99;
    #1;
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_priority got=%b exp=0", wr_ready); end
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      n_tests++;
      if (wr_ready !== (i == 32)) begin
        n_fail++; $display("FAIL clr_wr_ready cycle=%0d got=%b exp=%b", i, wr_ready, (i == 32));
      end
      if (i < 32) @(negedge clk);
    end
    wr_valid = 1'b0;
    do_read(5'd5);
    n_tests++; if (character !== 8'h55) begin n_fail++; $display("FAIL clr_front_kept got=%h exp=55", character); end
    pulse_swap();
    toggle_frame();
    n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL clr_swap_done got=%b exp=1", swap_done); end
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      n_tests++;
      if (character !== 8'h20) begin n_fail++; $display("FAIL clr_sweep addr=%0d got=%h exp=20", a, character); end
    end
  endtask

  task automatic test_swap_during_clear();
    int bad;
    bad = 0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 4) swap_req = 1'b1;
      if (i == 5) swap_req = 1'b0;
      if (i == 10) frame_rate = ~frame_rate;
      @(negedge clk);
      if (swap_done !== 1'b0) bad++;
    end
    repeat (3) begin
      @(negedge clk);
      if (swap_done !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sdc_no_swap bad_cycles=%0d exp=0", bad); end
    n_tests++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL sdc_pending got=%b exp=1", swap_pending); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sdc_idle got=%b exp=1", wr_ready); end
    toggle_frame();
    n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL sdc_done got=%b exp=1", swap_done); end
    @(negedge clk);
    n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL sdc_done_once got=%b exp=0", swap_done); end
    n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL sdc_pending_clr got=%b exp=0", swap_pending); end
    do_read(5'd5);
    n_tests++; if (character !== 8'h20) begin n_fail++; $display("FAIL sdc_read5 got=%h exp=20", character); end
  endtask

  task automatic test_reset_mid_clear();
    do_write(5'd0, 8'h42);
    pulse_swap();
    toggle_frame();
    do_read(5'd0);
    n_tests++; if (character !== 8'h42) begin n_fail++; $display("FAIL rmc_setup got=%h exp=42", character); end
    do_write(5'd1, 8'h43);
    pulse_swap();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmc_wr_ready got=%b exp=0", wr_ready); end
    n_tests++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL rmc_pending got=%b exp=0", swap_pending); end
    n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL rmc_done got=%b exp=0", swap_done); end
    n_tests++; if (character !== 8'h20) begin n_fail++; $display("FAIL rmc_character got=%h exp=20", character); end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      n_tests++;
      if (wr_ready !== (i == 32)) begin
        n_fail++; $display("FAIL rmc_init cycle=%0d got=%b exp=%b", i, wr_ready, (i == 32));
      end
    end
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      n_tests++;
      if (character !== 8'h20) begin n_fail++; $display("FAIL rmc_sweep0 addr=%0d got=%h exp=20", a, character); end
    end
    pulse_swap();
    toggle_frame();
    n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL rmc_swap_done got=%b exp=1", swap_done); end
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      n_tests++;
      if (character !== 8'h20) begin n_fail++; $display("FAIL rmc_sweep1 addr=%0d got=%h exp=20", a, character); end
    end
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_deferred_swap();
    test_clear();
    test_swap_during_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
